// File: rtl/video_mnist_argmax_pkg.sv
// Shared constants for the MNIST argmax stage: default geometry, output field
// offsets inside m_axi4s.tdata and the reject code used when the optional
// confidence threshold (VIDEO_MNIST_ARGMAX_THRESHOLD_EN) rejects a pixel.
package video_mnist_argmax_pkg;

    localparam int DEFAULT_CLASS_NUM   = 10;
    localparam int DEFAULT_CHANNEL_NUM = 7;
    localparam int DEFAULT_CLASS_WIDTH = 4;
    localparam int DEFAULT_COUNT_WIDTH = 3;

    localparam int CLASS_LSB = 0;
    localparam int SCORE_LSB = DEFAULT_CLASS_WIDTH;
    localparam int TIE_BIT   = DEFAULT_CLASS_WIDTH + DEFAULT_COUNT_WIDTH;

    // One past the last valid class index, so it can never be a real winner
    localparam int REJECT_CODE = DEFAULT_CLASS_NUM;

    typedef struct packed {
        logic                           tie;
        logic [DEFAULT_COUNT_WIDTH-1:0] score;
        logic [DEFAULT_CLASS_WIDTH-1:0] class_idx;
    } result_t;

endpackage

// File: rtl/video_mnist_argmax_if.sv
// Generic AXI4-Stream bundle used for both the vote input and the result output.
interface video_mnist_argmax_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) ();

    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tuser,
        output tlast,
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tuser,
        input  tlast,
        input  tdata,
        input  tvalid,
        output tready
    );

endinterface

// File: rtl/video_mnist_argmax_popcount.sv
// Combinational vote counter for a single class.
module video_mnist_argmax_popcount #(
    parameter int CHANNEL_NUM = 7,
    parameter int COUNT_WIDTH = 3
) (
    input  logic [CHANNEL_NUM-1:0] votes,
    output logic [COUNT_WIDTH-1:0] count
);

    // Sum the set vote bits
    always_comb begin
        count = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            count = count + COUNT_WIDTH'(votes[i]);
        end
    end

endmodule

// File: rtl/video_mnist_argmax.sv
// Per-pixel argmax over class vote counts. Stage 1 counts votes per class,
// stage 2 picks the lowest-index maximum and flags ties. Both stages share one
// enable so the pipeline freezes as a whole under backpressure.
// Optional macro VIDEO_MNIST_ARGMAX_THRESHOLD_EN adds param_threshold; pixels
// whose best score is below it are reported with the reject class code.
module video_mnist_argmax
    import video_mnist_argmax_pkg::*;
#(
    parameter int TUSER_WIDTH   = 1,
    parameter int CLASS_NUM     = DEFAULT_CLASS_NUM,
    parameter int CHANNEL_NUM   = DEFAULT_CHANNEL_NUM,
    parameter int CLASS_WIDTH   = DEFAULT_CLASS_WIDTH,
    parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
    parameter int S_TDATA_WIDTH = CLASS_NUM * CHANNEL_NUM,
    parameter int M_TDATA_WIDTH = 1 + COUNT_WIDTH + CLASS_WIDTH
) (
    input  logic                   aclk,
    input  logic                   aresetn,
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
    input  logic [COUNT_WIDTH-1:0] param_threshold,
`endif
    video_mnist_argmax_if.slave    s_axi4s,
    video_mnist_argmax_if.master   m_axi4s
);

    logic                     cke;
    logic [S_TDATA_WIDTH-1:0] s_data;
    logic [COUNT_WIDTH-1:0]   cnt_comb [CLASS_NUM];

    logic                     st1_valid;
    logic [TUSER_WIDTH-1:0]   st1_user;
    logic                     st1_last;
    logic [COUNT_WIDTH-1:0]   st1_cnt [CLASS_NUM];

    logic [COUNT_WIDTH-1:0]   best_cnt;
    logic [CLASS_WIDTH-1:0]   best_idx;
    logic [CLASS_WIDTH-1:0]   res_class;
    logic                     tie_flag;

    logic                     m_valid;
    logic [M_TDATA_WIDTH-1:0] m_data;
    logic [TUSER_WIDTH-1:0]   m_user;
    logic                     m_last;

    assign cke            = !m_valid || m_axi4s.tready;
    assign s_axi4s.tready = cke;
    assign s_data         = s_axi4s.tdata;

    for (genvar c = 0; c < CLASS_NUM; c++) begin : g_pop
        video_mnist_argmax_popcount #(
            .CHANNEL_NUM (CHANNEL_NUM),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_popcount (
            .votes (s_data[c*CHANNEL_NUM +: CHANNEL_NUM]),
            .count (cnt_comb[c])
        );
    end

    // Stage 1: register per-class counts with the beat's valid and sideband
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            st1_valid <= 1'b0;
            st1_user  <= '0;
            st1_last  <= 1'b0;
            for (int c = 0; c < CLASS_NUM; c++) begin
                st1_cnt[c] <= '0;
            end
        end else if (cke) begin
            st1_valid <= s_axi4s.tvalid;
            st1_user  <= s_axi4s.tuser;
            st1_last  <= s_axi4s.tlast;
            for (int c = 0; c < CLASS_NUM; c++) begin
                st1_cnt[c] <= cnt_comb[c];
            end
        end
    end

    // Stage 2 combinational: strict-greater scan keeps the lowest winning index
    always_comb begin
        best_cnt = st1_cnt[0];
        best_idx = '0;
        for (int c = 1; c < CLASS_NUM; c++) begin
            if (st1_cnt[c] > best_cnt) begin
                best_cnt = st1_cnt[c];
                best_idx = CLASS_WIDTH'(c);
            end
        end
        tie_flag = 1'b0;
        for (int c = 0; c < CLASS_NUM; c++) begin
            if ((CLASS_WIDTH'(c) != best_idx) && (st1_cnt[c] == best_cnt)) begin
                tie_flag = 1'b1;
            end
        end
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        res_class = (best_cnt < param_threshold) ? CLASS_WIDTH'(CLASS_NUM) : best_idx;
`else
        res_class = best_idx;
`endif
    end

    // Stage 2: register the packed result {tie, score, class}
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_user  <= '0;
            m_last  <= 1'b0;
        end else if (cke) begin
            m_valid <= st1_valid;
            m_data  <= {tie_flag, best_cnt, res_class};
            m_user  <= st1_user;
            m_last  <= st1_last;
        end
    end

    assign m_axi4s.tvalid = m_valid;
    assign m_axi4s.tdata  = m_data;
    assign m_axi4s.tuser  = m_user;
    assign m_axi4s.tlast  = m_last;

endmodule

// File: tb/tb_video_mnist_argmax.sv
// Bench for video_mnist_argmax: directed vote table, backpressure, sideband,
// mid-stream reset and randomized traffic, all scored against a queue model.
// Define VIDEO_MNIST_ARGMAX_THRESHOLD_EN to also exercise the reject path.
module tb_video_mnist_argmax;
    import video_mnist_argmax_pkg::*;

    localparam int TW  = 1;
    localparam int CN  = 10;
    localparam int CH  = 7;
    localparam int CW  = 4;
    localparam int NW  = 3;
    localparam int S_W = CN * CH;
    localparam int M_W = 1 + NW + CW;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    int   thr_now = 0;

    always #5 aclk = ~aclk;

    video_mnist_argmax_if #(.DATA_WIDTH(S_W), .USER_WIDTH(TW)) s_axi4s ();
    video_mnist_argmax_if #(.DATA_WIDTH(M_W), .USER_WIDTH(TW)) m_axi4s ();

`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
    logic [NW-1:0] param_threshold;
    assign param_threshold = NW'(thr_now);
`endif

    video_mnist_argmax #(
        .TUSER_WIDTH (TW),
        .CLASS_NUM   (CN),
        .CHANNEL_NUM (CH),
        .CLASS_WIDTH (CW),
        .COUNT_WIDTH (NW)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        .param_threshold (param_threshold),
`endif
        .s_axi4s         (s_axi4s),
        .m_axi4s         (m_axi4s)
    );

    typedef struct {
        logic [CW-1:0] cls;
        logic [NW-1:0] score;
        logic          tie;
        logic          user;
        logic          last;
    } exp_t;

    typedef struct {
        logic [S_W-1:0] votes;
        logic [CW-1:0]  cls;
        logic [NW-1:0]  score;
        logic           tie;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: count votes per class with $countones, first maximum wins
    function automatic exp_t model(input logic [S_W-1:0] v, input logic u, input logic l, input int thr);
        exp_t r;
        int   cnt [CN];
        int   best_cnt = -1;
        int   best     = 0;
        int   n_eq     = 0;
        for (int c = 0; c < CN; c++) begin
            cnt[c] = $countones(v[c*CH +: CH]);
            if (cnt[c] > best_cnt) begin
                best_cnt = cnt[c];
                best     = c;
            end
        end
        for (int c = 0; c < CN; c++) begin
            if (cnt[c] == best_cnt) n_eq++;
        end
        r.cls   = (best_cnt < thr) ? CW'(REJECT_CODE) : CW'(best);
        r.score = NW'(best_cnt);
        r.tie   = (n_eq > 1);
        r.user  = u;
        r.last  = l;
        return r;
    endfunction

    function automatic logic [S_W-1:0] setClass(input logic [S_W-1:0] v, input int c, input logic [CH-1:0] p);
        logic [S_W-1:0] r = v;
        r[c*CH +: CH] = p;
        return r;
    endfunction

    // Scoreboard: record accepted beats and compare every output handshake
    logic [M_W-1:0] held_data;
    logic           held_user;
    logic           held_last;
    bit             held_v = 1'b0;
    exp_t           sb_e;
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            if (s_axi4s.tvalid && s_axi4s.tready)
                exp_q.push_back(model(s_axi4s.tdata, s_axi4s.tuser[0], s_axi4s.tlast, thr_now));
            if (held_v && m_axi4s.tvalid) begin
                checkOutput("stall_data", 32'(m_axi4s.tdata), 32'(held_data));
                checkOutput("stall_user", 32'(m_axi4s.tuser), 32'(held_user));
                checkOutput("stall_last", 32'(m_axi4s.tlast), 32'(held_last));
            end
            if (m_axi4s.tvalid && !m_axi4s.tready) begin
                checkOutput("stall_s_tready", 32'(s_axi4s.tready), 32'd0);
                held_data = m_axi4s.tdata;
                held_user = m_axi4s.tuser[0];
                held_last = m_axi4s.tlast;
                held_v    = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            if (m_axi4s.tvalid && m_axi4s.tready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_beat", 32'd1, 32'd0);
                end else begin
                    sb_e = exp_q.pop_front();
                    checkOutput("sb_class", 32'(m_axi4s.tdata[CLASS_LSB +: CW]), 32'(sb_e.cls));
                    checkOutput("sb_score", 32'(m_axi4s.tdata[SCORE_LSB +: NW]), 32'(sb_e.score));
                    checkOutput("sb_tie",   32'(m_axi4s.tdata[TIE_BIT]), 32'(sb_e.tie));
                    checkOutput("sb_tuser", 32'(m_axi4s.tuser), 32'(sb_e.user));
                    checkOutput("sb_tlast", 32'(m_axi4s.tlast), 32'(sb_e.last));
                end
            end
        end
    end

    // Drive one beat from posedge+1 and hold it until accepted
    task automatic applyStimulus(input logic [S_W-1:0] v, input logic u, input logic l);
        int waited = 0;
        s_axi4s.tdata  = v;
        s_axi4s.tuser  = TW'(u);
        s_axi4s.tlast  = l;
        s_axi4s.tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_axi4s.tready) break;
            waited++;
            if (waited > 200) begin
                checkOutput("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_axi4s.tvalid = 1'b0;
    endtask

    // Single directed beat: latency (acceptance edge counts as 1) and fields
    task automatic runVector(input string name, input vec_t t);
        int lat = 1;
        applyStimulus(t.votes, 1'b0, 1'b0);
        forever begin
            @(negedge aclk);
            if (m_axi4s.tvalid || lat > 20) break;
            lat++;
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd2);
        checkOutput({name, "_class"}, 32'(m_axi4s.tdata[CLASS_LSB +: CW]), 32'(t.cls));
        checkOutput({name, "_score"}, 32'(m_axi4s.tdata[SCORE_LSB +: NW]), 32'(t.score));
        checkOutput({name, "_tie"},   32'(m_axi4s.tdata[TIE_BIT]), 32'(t.tie));
        @(posedge aclk);
        #1;
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || m_axi4s.tvalid) && n < 100) begin
            @(negedge aclk);
            n++;
        end
        checkOutput(name, 32'(exp_q.size()), 32'd0);
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [S_W-1:0] randVotes();
        logic [S_W-1:0] v = '0;
        for (int c = 0; c < CN; c++) begin
            v = setClass(v, c, CH'($urandom) & CH'($urandom));
        end
        return v;
    endfunction

    vec_t           vecs[$];
    vec_t           t;
    logic [S_W-1:0] v;
    bit             stream_done;

    initial begin
        s_axi4s.tdata  = '0;
        s_axi4s.tuser  = '0;
        s_axi4s.tlast  = 1'b0;
        s_axi4s.tvalid = 1'b0;
        m_axi4s.tready = 1'b1;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checkOutput("reset_m_tvalid", 32'(m_axi4s.tvalid), 32'd0);
        checkOutput("reset_m_tdata",  32'(m_axi4s.tdata), 32'd0);
        checkOutput("reset_m_tuser",  32'(m_axi4s.tuser), 32'd0);
        checkOutput("reset_m_tlast",  32'(m_axi4s.tlast), 32'd0);
        checkOutput("reset_s_tready", 32'(s_axi4s.tready), 32'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Directed vote table
        t.votes = setClass('0, 3, 7'b1111111);
        t.cls = 4'd3; t.score = 3'd7; t.tie = 1'b0; vecs.push_back(t);
        v = setClass('0, 2, 7'b0000111);
        v = setClass(v, 5, 7'b1010100);
        v = setClass(v, 0, 7'b0000011);
        v = setClass(v, 7, 7'b1000000);
        t.votes = v; t.cls = 4'd2; t.score = 3'd3; t.tie = 1'b1; vecs.push_back(t);
        t.votes = '0; t.cls = 4'd0; t.score = 3'd0; t.tie = 1'b1; vecs.push_back(t);
        t.votes = setClass('0, 9, 7'b1111111);
        t.cls = 4'd9; t.score = 3'd7; t.tie = 1'b0; vecs.push_back(t);
        t.votes = setClass('0, 0, 7'b0100000);
        t.cls = 4'd0; t.score = 3'd1; t.tie = 1'b0; vecs.push_back(t);
        v = setClass('0, 8, 7'b0011111);
        v = setClass(v, 4, 7'b1111100);
        v = setClass(v, 1, 7'b0111111);
        t.votes = v; t.cls = 4'd1; t.score = 3'd6; t.tie = 1'b0; vecs.push_back(t);
        v = setClass('0, 4, 7'b1110000);
        v = setClass(v, 9, 7'b0000111);
        t.votes = v; t.cls = 4'd4; t.score = 3'd3; t.tie = 1'b1; vecs.push_back(t);
        for (int i = 0; i < vecs.size(); i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end
        waitDrain("table_drain");

        // Backpressure: 8 back-to-back beats, sink stalls 5 cycles mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) applyStimulus(randVotes(), 1'b0, 1'b0);
            end
            begin
                repeat (3) @(posedge aclk);
                #1 m_axi4s.tready = 1'b0;
                repeat (5) @(posedge aclk);
                #1 m_axi4s.tready = 1'b1;
            end
        join
        waitDrain("backpressure_drain");

        // Sideband alignment over a 28-beat line
        for (int i = 0; i < 28; i++) begin
            applyStimulus(randVotes(), (i == 0), (i == 27));
        end
        waitDrain("sideband_drain");

        // Reset with both stages holding valid data
        applyStimulus(randVotes(), 1'b1, 1'b0);
        applyStimulus(randVotes(), 1'b0, 1'b1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("midreset_m_tvalid", 32'(m_axi4s.tvalid), 32'd0);
        checkOutput("midreset_s_tready", 32'(s_axi4s.tready), 32'd1);
        @(posedge aclk);
        #1;
        t.votes = setClass('0, 5, 7'b0011111);
        t.cls = 4'd5; t.score = 3'd5; t.tie = 1'b0;
        runVector("post_reset", t);
        waitDrain("post_reset_drain");

`ifdef VIDEO_MNIST_ARGMAX_THRESHOLD_EN
        thr_now = 4;
        t.votes = setClass('0, 6, 7'b0000111);
        t.cls = CW'(REJECT_CODE); t.score = 3'd3; t.tie = 1'b0;
        runVector("thr_reject", t);
        t.votes = setClass('0, 6, 7'b0011111);
        t.cls = 4'd6; t.score = 3'd5; t.tie = 1'b0;
        runVector("thr_accept", t);
        waitDrain("thr_drain");
        thr_now = 0;
`endif

        // Randomized traffic with idle gaps and random sink stalls
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge aclk);
                        #1;
                    end
                    applyStimulus(randVotes(), 1'($urandom), 1'($urandom));
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge aclk);
                    #1 m_axi4s.tready = ($urandom_range(0, 3) != 0);
                end
                m_axi4s.tready = 1'b1;
            end
        join
        waitDrain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

endmodule
